pipeline_hazard_reg: RTL

Parametrised inter-stage pipeline register for the in-order core (EX/MEM boundary and reusable at other stage boundaries). It carries a valid bit plus a widened payload. It adds downstream hold and external flush. It replaces single-cycle stall detection with a counter-driven hazard FSM that inserts a configurable number of bubbles after loads and squashes a configurable number of wrong-path instructions after taken branches/JAL. It also keeps a saturating bubble statistics counter.

---
 rtl/pipeline_hazard_reg.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_reg.sv
// Inter-stage pipeline register with downstream hold, external flush, and a
// counter-driven hazard FSM that inserts load-use bubbles and squashes wrong-path slots.
module pipeline_hazard_reg #(
    parameter int unsigned       DATA_W         = 32,
    parameter int unsigned       CTRL_W         = 2,
    parameter int unsigned       TYPE_W         = 4,
    parameter logic [TYPE_W-1:0] OP_LW          = 4'h9,
    parameter logic [TYPE_W-1:0] OP_BR          = 4'h2,
    parameter logic [TYPE_W-1:0] OP_JAL         = 4'hB,
    parameter int unsigned       LOAD_BUBBLES   = 1,
    parameter int unsigned       BRANCH_BUBBLES = 2,
    parameter logic [DATA_W-1:0] RESET_VALUE    = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              flush,
    input  logic              in_valid,
    input  logic              in_reg_wr_en,
    input  logic              in_is_load,
    input  logic              in_is_store,
    input  logic              in_br_taken,
    input  logic [CTRL_W-1:0] in_mul_sel,
    input  logic [TYPE_W-1:0] in_inst_type,
    input  logic [DATA_W-1:0] in_alu_out,
    input  logic [DATA_W-1:0] in_data2,
    input  logic [DATA_W-1:0] in_pc,
    output logic              out_valid,
    output logic              out_reg_wr_en,
    output logic              out_is_load,
    output logic              out_is_store,
    output logic [CTRL_W-1:0] out_mul_sel,
    output logic [TYPE_W-1:0] out_inst_type,
    output logic [DATA_W-1:0] out_alu_out,
    output logic [DATA_W-1:0] out_data2,
    output logic [DATA_W-1:0] out_pc,
    output logic              stall_upstream,
    output logic [15:0]       bubble_count
);

    typedef enum logic [1:0] {RUN, LOAD_BUB, SQUASH} state_e;

    typedef struct packed {
        logic valid;
        logic reg_wr_en;
        logic is_load;
        logic is_store;
    } ctrl_t;

    typedef struct packed {
        logic [CTRL_W-1:0] mul_sel;
        logic [TYPE_W-1:0] inst_type;
        logic [DATA_W-1:0] alu_out;
        logic [DATA_W-1:0] data2;
        logic [DATA_W-1:0] pc;
    } payload_t;

    localparam logic [3:0] LOAD_CNT   = 4'(LOAD_BUBBLES);
    localparam logic [3:0] BRANCH_CNT = 4'(BRANCH_BUBBLES);
    localparam payload_t PAYLOAD_RST = '{
        mul_sel:   RESET_VALUE[CTRL_W-1:0],
        inst_type: RESET_VALUE[TYPE_W-1:0],
        alu_out:   RESET_VALUE,
        data2:     RESET_VALUE,
        pc:        RESET_VALUE
    };

    state_e   state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    ctrl_t    ctrl_q, ctrl_d;
    payload_t payload_q, payload_d;
    logic [15:0] bub_q, bub_d;

    payload_t in_payload;
    ctrl_t    in_ctrl;
    logic     load_hazard;
    logic     branch_hazard;
    logic [15:0] bub_inc;

    assign in_payload = '{
        mul_sel:   in_mul_sel,
        inst_type: in_inst_type,
        alu_out:   in_alu_out,
        data2:     in_data2,
        pc:        in_pc
    };
    // An invalid slot must never carry live control bits downstream.
    assign in_ctrl = '{
        valid:     in_valid,
        reg_wr_en: in_reg_wr_en & in_valid,
        is_load:   in_is_load & in_valid,
        is_store:  in_is_store & in_valid
    };

    assign load_hazard   = in_valid && (in_inst_type == OP_LW) && (LOAD_BUBBLES != 0);
    assign branch_hazard = in_valid && (BRANCH_BUBBLES != 0) &&
                           (((in_inst_type == OP_BR) && in_br_taken) || (in_inst_type == OP_JAL));
    assign bub_inc       = (bub_q == 16'hFFFF) ? bub_q : bub_q + 16'd1;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        ctrl_d    = ctrl_q;
        payload_d = payload_q;
        bub_d     = bub_q;
        if (flush) begin
            state_d   = RUN;
            cnt_d     = '0;
            ctrl_d    = '0;
            payload_d = in_payload;
            bub_d     = bub_inc;
        end else if (!hold) begin
            unique case (state_q)
                RUN: begin
                    ctrl_d    = in_ctrl;
                    payload_d = in_payload;
                    if (load_hazard) begin
                        state_d = LOAD_BUB;
                        cnt_d   = LOAD_CNT;
                    end else if (branch_hazard) begin
                        state_d = SQUASH;
                        cnt_d   = BRANCH_CNT;
                    end
                end
                LOAD_BUB: begin
                    // Input stays upstream; payload is left as-is behind the bubble.
                    ctrl_d = '0;
                    cnt_d  = cnt_q - 4'd1;
                    bub_d  = bub_inc;
                    if (cnt_q <= 4'd1) state_d = RUN;
                end
                SQUASH: begin
                    ctrl_d    = '0;
                    payload_d = in_payload;
                    cnt_d     = cnt_q - 4'd1;
                    bub_d     = bub_inc;
                    if (cnt_q <= 4'd1) state_d = RUN;
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments; reset is sampled on the edge.
        if (!reset) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            ctrl_q    <= '0;
            payload_q <= PAYLOAD_RST;
            bub_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ctrl_q    <= ctrl_d;
            payload_q <= payload_d;
            bub_q     <= bub_d;
        end
    end

    assign stall_upstream = ~flush & (hold | (state_q == LOAD_BUB));

    assign out_valid     = ctrl_q.valid;
    assign out_reg_wr_en = ctrl_q.reg_wr_en;
    assign out_is_load   = ctrl_q.is_load;
    assign out_is_store  = ctrl_q.is_store;
    assign out_mul_sel   = payload_q.mul_sel;
    assign out_inst_type = payload_q.inst_type;
    assign out_alu_out   = payload_q.alu_out;
    assign out_data2     = payload_q.data2;
    assign out_pc        = payload_q.pc;
    assign bubble_count  = bub_q;

endmodule
